min_sec_timebase: RTL
=====================

# min_sec_timebase

Upstream timekeeping stage of the 12-hour clock: divides the system clock down to a one-second tick and keeps seconds and minutes (each 00–59, BCD). Emits a one-cycle `hour_tick` on every 59:59 → 00:00 rollover, which drives the hour counter's `enable` input. Also provides manual time-setting pulses for minutes and hours.

## Interface
- `TICKS_PER_SEC`, 50_000_000, number of `clk` cycles per second; must be ≥ 2.
- `PW`, $clog2(TICKS_PER_SEC), prescaler width (derived; not overridden).

- `clk` input 1: system clock, all logic on posedge.
- `reset` input 1: synchronous, active-low; sampled on posedge `clk`.
- `enable` input 1: run/stop; low freezes the prescaler and the seconds count.
- `set_min` input 1: each cycle high = one manual minute step.
- `set_hour` input 1: each cycle high = one manual hour step.
- `sec_bcd` output 8: seconds, BCD {tens[7:4], ones[3:0]}, 00–59.
- `min_bcd` output 8: minutes, BCD, 00–59.
- `sec_tick` output 1: one-cycle pulse, high in the cycle the new seconds value first appears.
- `hour_tick` output 1: one-cycle pulse advancing the hour counter.
- `colon` output 1: display colon drive (see Configuration).

## Operation
- Prescaler `pcnt` (PW bits) counts 0 … TICKS_PER_SEC−1 while `enable`=1 and holds while `enable`=0.
- Second event: `enable`=1 and `pcnt`=TICKS_PER_SEC−1. `pcnt` wraps to 0 and seconds advance.
- BCD digit rules:
  - ones 9 → 0 with a carry to tens.
  - tens 5 with ones 9 → 00 with a carry to minutes.
  - minutes carry into 59 → 00 and assert `hour_tick`.
- Only legal BCD values are ever produced. No binary-to-BCD conversion is used; digits are counted directly.
- Per-cycle priority (highest first):
  1. `reset`=0: `pcnt`=0, `sec_bcd`=8'h00, `min_bcd`=8'h00, `sec_tick`=0, `hour_tick`=0, `colon`=1.
  2. `set_min`=1: `min_bcd` +1 mod 60 with no hour carry; `sec_bcd`=00; `pcnt`=0; no `sec_tick`; no `hour_tick`. A simultaneous second event is discarded.
  3. `set_hour`=1: `hour_tick`=1 on the next cycle. Seconds and minutes are untouched. A second event in the same cycle still advances seconds, but its `hour_tick` merges with the set pulse, so the hour advances once only.
  4. Second event: normal counting as above.
- Set inputs act regardless of `enable`.
- Holding a set input high for N cycles gives N steps. Debouncing and edge detection happen upstream.

## Timing
- All outputs are registered and change only on posedge `clk`.
- `sec_tick` and `hour_tick` are high for exactly one cycle, the same cycle the updated `sec_bcd`/`min_bcd` is visible.
- Latency: 1 cycle from the qualifying input edge (second event, `set_min`, `set_hour`) to the output change.
- With `enable` held at 1, consecutive `sec_tick` pulses are exactly TICKS_PER_SEC cycles apart.
- `hour_tick` accompanies the `min_bcd`=00, `sec_bcd`=00 update.
- Reset mid-count clears everything the next edge; the first `sec_tick` after release comes TICKS_PER_SEC cycles after the first cycle with `reset`=1 and `enable`=1.
- Deasserting `enable` at `pcnt`=k and reasserting it later resumes from k. No partial second is lost.

## Configuration
- `TIMEBASE_COLON_EN` defined:
  - `colon`=1 while `pcnt` < TICKS_PER_SEC/2, otherwise 0 (1 Hz blink, 50 % duty, registered).
  - Reset forces 1.
  - `set_min` restarts the phase at 1.
  - While `enable`=0, `colon` holds its value.
- Not defined: `colon` is constant 1, and no compare logic is generated.

## Test plan
- TICKS_PER_SEC=4, reset released, `enable`=1 for 40 cycles → `sec_tick` every 4 cycles, `sec_bcd` reaches 8'h10 after 10 ticks (08 → 09 → 10 BCD sequence), `hour_tick` never asserts.
- Preload via 59 `set_min` pulses, then run 60 seconds → at 59:59 → 00:00, `min_bcd`=00, `sec_bcd`=00, `hour_tick` high exactly 1 cycle coinciding with `sec_tick`.
- `set_min` held 3 cycles from 58:xx → `min_bcd` 59 → 00 → 01, `sec_bcd`=00, `hour_tick` stays 0.
- `set_hour` pulse on the same cycle as the 59:59 rollover → exactly one `hour_tick`, counter shows 00:00.
- `enable` dropped at `pcnt`=2 for 10 cycles, then restored → next `sec_tick` 2 cycles after restore. `reset`=0 mid-run → all outputs zero (`colon`=1) on the next edge.
- With `TIMEBASE_COLON_EN`, TICKS_PER_SEC=4 → `colon` pattern 1,1,0,0 repeating. Without the macro, `colon` is constant 1.

Source files
------------

// File: rtl/min_sec_timebase_if.sv
// Signal bundle between the minute/second timebase and its user: run/set controls in,
// BCD time, tick pulses and colon drive out.
interface min_sec_timebase_if;
  logic       enable;
  logic       set_min;
  logic       set_hour;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       sec_tick;
  logic       hour_tick;
  logic       colon;

  // There is no valid/ready pair here. Controls are level-sampled on every posedge,
  // one step per cycle held high. Ticks are one-cycle pulses aligned with the BCD update.
  modport master (
    output enable, set_min, set_hour,
    input  sec_bcd, min_bcd, sec_tick, hour_tick, colon
  );

  modport slave (
    input  enable, set_min, set_hour,
    output sec_bcd, min_bcd, sec_tick, hour_tick, colon
  );
endinterface

// File: rtl/min_sec_timebase.sv
// One-second prescaler plus BCD seconds/minutes counters feeding the hour counter.
// Optional colon blink is built when TIMEBASE_COLON_EN is defined.
module min_sec_timebase #(
  parameter  int TICKS_PER_SEC = 50_000_000,
  localparam int PW            = $clog2(TICKS_PER_SEC)
) (
  input  logic          clk,
  input  logic          reset,
  min_sec_timebase_if.slave bus
);

  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic          sec_tick_q, sec_tick_d;
  logic          hour_tick_q, hour_tick_d;
  logic          sec_evt;
  logic [8:0]    sec_inc, min_inc;

  // Returns {carry, next} for a 00..59 BCD pair, stepping the digits directly.
  function automatic logic [8:0] bcd60_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 9'h100;
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    end
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign sec_evt = bus.enable && (pcnt_q == PMAX);
  assign sec_inc = bcd60_inc(sec_q);
  assign min_inc = bcd60_inc(min_q);

  always_comb begin
    pcnt_d      = pcnt_q;
    sec_d       = sec_q;
    min_d       = min_q;
    sec_tick_d  = 1'b0;
    hour_tick_d = 1'b0;
    if (bus.set_min) begin
      // Manual minute step restarts the second and swallows any coincident second event.
      min_d  = min_inc[7:0];
      sec_d  = 8'h00;
      pcnt_d = '0;
    end else begin
      hour_tick_d = bus.set_hour;
      if (sec_evt) begin
        pcnt_d     = '0;
        sec_tick_d = 1'b1;
        sec_d      = sec_inc[7:0];
        if (sec_inc[8]) begin
          min_d = min_inc[7:0];
          // Rollover pulse ORs with a manual hour step so the hour moves once.
          if (min_inc[8]) hour_tick_d = 1'b1;
        end
      end else if (bus.enable) begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt_q      <= '0;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      sec_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      sec_tick_q  <= sec_tick_d;
      hour_tick_q <= hour_tick_d;
    end
  end

  assign bus.sec_bcd   = sec_q;
  assign bus.min_bcd   = min_q;
  assign bus.sec_tick  = sec_tick_q;
  assign bus.hour_tick = hour_tick_q;

`ifdef TIMEBASE_COLON_EN
  localparam logic [PW-1:0] HALF = PW'(TICKS_PER_SEC / 2);
  logic colon_q;

  // Derived from the next prescaler value so it stays in phase and holds when paused.
  always_ff @(posedge clk) begin
    if (!reset) colon_q <= 1'b1;
    else        colon_q <= (pcnt_d < HALF);
  end

  assign bus.colon = colon_q;
`else
  assign bus.colon = 1'b1;
`endif

endmodule
